// File: rtl/mini_core_pkg.sv
// Shared types and sizes for the mini_core fetch path.
// MINI_CORE_FETCH_MISALIGN_CHK_EN adds a misalign flag to each fetch entry.
package mini_core_pkg;

    localparam int MSB_I_MEM       = 9;
    localparam int IMEM_WORD_AW    = MSB_I_MEM - 1;
    localparam int SIZE_I_MEM      = 4 << IMEM_WORD_AW;  // bytes
    localparam int FETCH_BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef MINI_CORE_FETCH_MISALIGN_CHK_EN
        logic        misalign;
`endif
    } t_fetch_entry;

endpackage

// File: rtl/mini_core_fetch_buf.sv
// Small push/pop FIFO of fetch entries with flush; head is always visible.
// MINI_CORE_FETCH_MISALIGN_CHK_EN only widens the stored entry.
module mini_core_fetch_buf
    import mini_core_pkg::*;
(
    input  logic         clock,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  t_fetch_entry push_data,
    input  logic         pop,
    output t_fetch_entry head,
    output logic [1:0]   count
);

    // Pointer wrap relies on a power-of-two depth.
    localparam int PTR_W = $clog2(FETCH_BUF_DEPTH);

    t_fetch_entry     entries [FETCH_BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) entries[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/mini_core_fetch.sv
// Fetch stage: owns the PC, issues reads to i_mem port A, buffers returns for decode.
// MINI_CORE_FETCH_MISALIGN_CHK_EN adds fetch_misalign for unaligned redirect targets.
module mini_core_fetch
    import mini_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = MSB_I_MEM - 1
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_address,
    output logic               imem_rden,
    input  logic [31:0]        imem_q,
    output logic               imem_wren,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [31:0]        fetch_pc,
    output logic [31:0]        fetch_instr
`ifdef MINI_CORE_FETCH_MISALIGN_CHK_EN
    ,
    output logic               fetch_misalign
`endif
);

    logic [31:0]  pc_reg;
    logic         inflight;
    logic [31:0]  inflight_pc;
    logic         inflight_mis;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    logic         deq;
    logic         issue;
    logic         push;
    logic [31:0]  redirect_aligned;
    t_fetch_entry push_data;
    t_fetch_entry head;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign deq              = fetch_valid & fetch_ready;
    // Entries that will be buffered or in flight after this edge; keeps a return from ever hitting a full FIFO.
    assign occupancy        = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
    assign issue            = occupancy < 3'd2;

    // Gated by rst_n so the port is quiet while reset is asserted.
    assign imem_rden    = rst_n & (redirect_valid | issue);
    assign imem_address = redirect_valid ? redirect_aligned[IMEM_AW+1:2] : pc_reg[IMEM_AW+1:2];
    assign imem_wren    = 1'b0;

    // A return that coincides with a redirect belongs to the abandoned path.
    assign push            = inflight & ~redirect_valid;
    assign push_data.pc    = inflight_pc;
    assign push_data.instr = imem_q;

`ifdef MINI_CORE_FETCH_MISALIGN_CHK_EN
    assign push_data.misalign = inflight_mis;
    assign fetch_misalign     = head.misalign;
`else
    logic unused_misalign;
    assign unused_misalign = inflight_mis ^ (^redirect_pc[1:0]);
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            inflight_mis <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg       <= redirect_aligned + 32'd4;
            inflight     <= 1'b1;
            inflight_pc  <= redirect_aligned;
            inflight_mis <= |redirect_pc[1:0];
        end else if (issue) begin
            pc_reg       <= pc_reg + 32'd4;
            inflight     <= 1'b1;
            inflight_pc  <= pc_reg;
            inflight_mis <= 1'b0;
        end else begin
            inflight     <= 1'b0;
        end
    end

    mini_core_fetch_buf u_buf (
        .clock     (clock),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (deq),
        .head      (head),
        .count     (count)
    );

    assign fetch_valid = count != 2'd0;
    assign fetch_pc    = head.pc;
    assign fetch_instr = head.instr;

endmodule

// File: tb/tb_mini_core_fetch.sv
// Directed bench for mini_core_fetch with a 1-cycle registered i_mem model (word k = 0x1000_0000 + k).
// Define MINI_CORE_FETCH_MISALIGN_CHK_EN to also check fetch_misalign.
module tb_mini_core_fetch;
    import mini_core_pkg::*;

    localparam int AW = MSB_I_MEM - 1;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [AW-1:0] imem_address;
    logic          imem_rden;
    logic [31:0]   imem_q = '0;
    logic          imem_wren;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_instr;
`ifdef MINI_CORE_FETCH_MISALIGN_CHK_EN
    logic          fetch_misalign;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    mini_core_fetch #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_address   (imem_address),
        .imem_rden      (imem_rden),
        .imem_q         (imem_q),
        .imem_wren      (imem_wren),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr)
`ifdef MINI_CORE_FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (imem_rden) imem_q <= 32'h1000_0000 + 32'(imem_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clock);
        chk("rst_valid", 32'(fetch_valid), 0);
        chk("rst_pc",    fetch_pc,         0);
        chk("rst_instr", fetch_instr,      0);
        chk("rst_rden",  32'(imem_rden),   0);
        chk("rst_wren",  32'(imem_wren),   0);

        // 1: fill and stream
        fetch_ready = 1'b1; rst_n = 1'b1; #1;
        chk("t1_rden", 32'(imem_rden),    1);
        chk("t1_addr", 32'(imem_address), 0);
        step(); chk("t1_valid_c1", 32'(fetch_valid), 0);
        step(); chk("t1_valid_c2", 32'(fetch_valid), 1);
        chk("t1_pc0", fetch_pc, 0);
        chk("t1_in0", fetch_instr, 32'h1000_0000);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t1_pc", fetch_pc, 32'(4 * k));
            chk("t1_in", fetch_instr, 32'h1000_0000 + 32'(k));
        end

        // 2: back-pressure after first accept
        do_reset(); step(); step();
        chk("t2_pc0", fetch_pc, 0);
        step(); fetch_ready = 1'b0;
        chk("t2_pc4", fetch_pc, 4);
        step();
        chk("t2_rden_off", 32'(imem_rden), 0);
        chk("t2_hold_pc",  fetch_pc, 4);
        step(); step();
        chk("t2_hold_pc2", fetch_pc, 4);
        chk("t2_hold_in",  fetch_instr, 32'h1000_0001);
        chk("t2_rden_off2", 32'(imem_rden), 0);
        fetch_ready = 1'b1; #1;
        chk("t2_rden_on", 32'(imem_rden), 1);
        chk("t2_d4", fetch_pc, 4);
        step(); chk("t2_d8", fetch_pc, 8);
        step(); chk("t2_d12", fetch_pc, 12);
        chk("t2_d12_valid", 32'(fetch_valid), 1);

        // 3: redirect with buffered entry and read in flight
        fetch_ready = 1'b0; do_reset(); step(); step();
        chk("t3_pre_pc", fetch_pc, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        chk("t3_rden", 32'(imem_rden), 1);
        chk("t3_addr", 32'(imem_address), 32'h10);
        step(); redirect_valid = 1'b0; fetch_ready = 1'b1; #1;
        chk("t3_flushed", 32'(fetch_valid), 0);
        chk("t3_addr2", 32'(imem_address), 32'h11);
        step();
        chk("t3_pc40", fetch_pc, 32'h40);
        chk("t3_in40", fetch_instr, 32'h1000_0010);
        step();
        chk("t3_pc44", fetch_pc, 32'h44);
        chk("t3_in44", fetch_instr, 32'h1000_0011);

        // 4: back-to-back redirects, only the second survives
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step(); chk("t4_v_a", 32'(fetch_valid), 0);
        redirect_pc = 32'h100;
        step(); redirect_valid = 1'b0;
        chk("t4_v_b", 32'(fetch_valid), 0);
        step();
        chk("t4_pc100", fetch_pc, 32'h100);
        chk("t4_in100", fetch_instr, 32'h1000_0040);
        step();
        chk("t4_pc104", fetch_pc, 32'h104);

        // 5: wrap at the end of i_mem and at 2^32
        redirect_valid = 1'b1; redirect_pc = 32'(SIZE_I_MEM - 4);
        step(); redirect_valid = 1'b0; #1;
        chk("t5_addr_wrap", 32'(imem_address), 0);
        step();
        chk("t5_pc_last", fetch_pc, 32'(SIZE_I_MEM - 4));
        chk("t5_in_last", fetch_instr, 32'h1000_00FF);
        step();
        chk("t5_pc_size", fetch_pc, 32'(SIZE_I_MEM));
        chk("t5_in_size", fetch_instr, 32'h1000_0000);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); redirect_valid = 1'b0; step();
        chk("t5_pc_top", fetch_pc, 32'hFFFF_FFFC);
        step();
        chk("t5_pc_zero", fetch_pc, 32'h0);
        chk("t5_in_zero", fetch_instr, 32'h1000_0000);

        // 6: reset mid-stream with FIFO full
        fetch_ready = 1'b0; step(); step(); step();
        chk("t6_full_valid", 32'(fetch_valid), 1);
        chk("t6_full_rden", 32'(imem_rden), 0);
        rst_n = 1'b0; #1;
        chk("t6_async_valid", 32'(fetch_valid), 0);
        chk("t6_async_pc", fetch_pc, 0);
        chk("t6_async_rden", 32'(imem_rden), 0);
        step(); rst_n = 1'b1; fetch_ready = 1'b1;
        step(); step();
        chk("t6_valid", 32'(fetch_valid), 1);
        chk("t6_pc", fetch_pc, 32'h0);
        chk("t6_in", fetch_instr, 32'h1000_0000);

        // 7: unaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step(); redirect_valid = 1'b0; step();
        chk("t7_pc40", fetch_pc, 32'h40);
        chk("t7_in40", fetch_instr, 32'h1000_0010);
`ifdef MINI_CORE_FETCH_MISALIGN_CHK_EN
        chk("t7_mis1", 32'(fetch_misalign), 1);
`endif
        step();
        chk("t7_pc44", fetch_pc, 32'h44);
`ifdef MINI_CORE_FETCH_MISALIGN_CHK_EN
        chk("t7_mis0", 32'(fetch_misalign), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
